// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the multi-channel motor PID controller.
//   - control_mode encodings
//   - sequencer state enum
//   - wide signed helpers: symmetric clamp and two's-complement saturation.
//     The helpers work on a fixed 64-bit container, so callers sign-extend
//     into calc_t and truncate the result back to their own width.
package motor_pkg;

    localparam logic [7:0] MODE_PID      = 8'd0;
    localparam logic [7:0] MODE_PI       = 8'd1;
    localparam logic [7:0] MODE_DISABLED = 8'd2;
    localparam logic [7:0] MODE_DIRECT   = 8'd3;

    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_OUT
    } seq_state_t;

    // Clamp v to [-lim, +lim]; a negative limit behaves as 0.
    function automatic calc_t clamp_sym(input calc_t v, input calc_t lim);
        calc_t l;
        l = (lim < 0) ? '0 : lim;
        if (v > l)       return l;
        else if (v < -l) return -l;
        else             return v;
    endfunction

    // Saturate v to the range of a w-bit two's-complement number.
    function automatic calc_t sat_bits(input calc_t v, input int w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: control-rate tick generator.
//   CLK, reset : clock, async active-high reset
//   tick       : one-cycle pulse when the counter is at PERIOD-1
// The counter wraps on its own compare so the count never depends on
// anything that observes or drives the tick net.
module pid_tick_gen #(
    parameter int CLOCK_FREQ   = 16_000_000,
    parameter int CONTROL_FREQ = 1000
) (
    input  logic CLK,
    input  logic reset,
    output logic tick
);
    localparam int PERIOD = CLOCK_FREQ / CONTROL_FREQ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(PERIOD - 1));
    assign tick = wrap;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/multi_motor_pid.sv
// multi_motor_pid: time-multiplexed PID for NUM_CHANNELS motors, one multiplier.
//   CLK, reset            : clock, async active-high reset
//   setpoint..deadband    : packed per-channel signed operands, channel k at [k*DATA_W +: DATA_W]
//   control_mode          : packed per-channel 8-bit mode
//   duty                  : packed per-channel registered duty
//   duty_valid            : one-cycle pulse after the last channel is written
//   busy                  : sequencer not IDLE
//   tick_overrun          : sticky, tick arrived while busy
//   clear_overrun         : synchronous clear of tick_overrun (a new overrun wins)
// Each channel runs LOAD, MUL_P, MUL_I, MUL_D, OUT (5 cycles regardless of mode).
module multi_motor_pid
    import motor_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_W       = 24,
    parameter int CLOCK_FREQ   = 16_000_000,
    parameter int CONTROL_FREQ = 1000,
    parameter int ERR_SHIFT    = 10
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic [NUM_CHANNELS*DATA_W-1:0] setpoint,
    input  logic [NUM_CHANNELS*DATA_W-1:0] state,
    input  logic [NUM_CHANNELS*DATA_W-1:0] Kp,
    input  logic [NUM_CHANNELS*DATA_W-1:0] Ki,
    input  logic [NUM_CHANNELS*DATA_W-1:0] Kd,
    input  logic [NUM_CHANNELS*DATA_W-1:0] PWMLimit,
    input  logic [NUM_CHANNELS*DATA_W-1:0] IntegralLimit,
    input  logic [NUM_CHANNELS*DATA_W-1:0] deadband,
    input  logic [NUM_CHANNELS*8-1:0]      control_mode,
    output logic [NUM_CHANNELS*DATA_W-1:0] duty,
    output logic                           duty_valid,
    output logic                           busy,
    output logic                           tick_overrun,
    input  logic                           clear_overrun
);
    localparam int PERIOD = CLOCK_FREQ / CONTROL_FREQ;
    localparam int AW     = 2*DATA_W + 2;
    localparam int PW     = 2*DATA_W;
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef logic signed [DATA_W-1:0] dat_t;
    typedef logic signed [DATA_W:0]   ext_t;
    typedef logic signed [AW-1:0]     acc_t;

    generate
        if (5*NUM_CHANNELS + 1 >= PERIOD) begin : g_period_chk
            $error("multi_motor_pid: 5*NUM_CHANNELS+1 must be below CLOCK_FREQ/CONTROL_FREQ");
        end
        if (AW > CALC_W) begin : g_width_chk
            $error("multi_motor_pid: DATA_W too wide for the clamp helpers");
        end
    endgenerate

    logic tick;

    pid_tick_gen #(
        .CLOCK_FREQ   (CLOCK_FREQ),
        .CONTROL_FREQ (CONTROL_FREQ)
    ) u_tick (
        .CLK   (CLK),
        .reset (reset),
        .tick  (tick)
    );

    seq_state_t      state_q, state_d;
    logic [CH_W-1:0] ch_q;
    logic            last_ch;
    int              base;

    // Per-channel operands latched in LOAD, intermediates latched in MUL_P.
    dat_t       sp_r, st_r, kp_r, ki_r, kd_r, plim_r, ilim_r, db_r;
    logic [7:0] mode_r;
    dat_t       err_r, int_r, der_r;
    acc_t       acc_q;
    dat_t       integ_q [NUM_CHANNELS];
    dat_t       eprev_q [NUM_CHANNELS];

    ext_t                 diff, diff_sh, int_sum, der_sum;
    dat_t                 err_c, int_c, der_c;
    dat_t                 mul_a, mul_b;
    logic signed [PW-1:0] prod;
    acc_t                 acc_abs;
    logic                 in_dead;
    dat_t                 pid_duty, direct_duty;

    assign last_ch = (ch_q == CH_W'(NUM_CHANNELS - 1));
    assign busy    = (state_q != S_IDLE);
    assign base    = int'(ch_q) * DATA_W;

    always_comb begin
        // Error path is kept one bit wider than the operands so the
        // subtraction and integral sum cannot wrap before saturation.
        diff    = ext_t'(sp_r) - ext_t'(st_r);
        diff_sh = diff >>> ERR_SHIFT;
        err_c   = dat_t'(sat_bits(calc_t'(diff_sh), DATA_W));
        int_sum = ext_t'(integ_q[ch_q]) + ext_t'(err_c);
        int_c   = dat_t'(clamp_sym(calc_t'(int_sum), calc_t'(ilim_r)));
        der_sum = ext_t'(err_c) - ext_t'(eprev_q[ch_q]);
        der_c   = dat_t'(sat_bits(calc_t'(der_sum), DATA_W));

        case (state_q)
            S_MUL_I: begin mul_a = ki_r; mul_b = int_r; end
            S_MUL_D: begin mul_a = kd_r; mul_b = der_r; end
            default: begin mul_a = kp_r; mul_b = err_c; end
        endcase
        prod = PW'(mul_a) * PW'(mul_b);

        // Limit and deadband decisions look at the full accumulator.
        acc_abs     = (acc_q < 0) ? -acc_q : acc_q;
        in_dead     = calc_t'(acc_abs) <= calc_t'(db_r);
        pid_duty    = in_dead ? '0 : dat_t'(clamp_sym(calc_t'(acc_q), calc_t'(plim_r)));
        direct_duty = dat_t'(clamp_sym(calc_t'(sp_r), calc_t'(plim_r)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tick) state_d = S_LOAD;
            S_LOAD:  state_d = S_MUL_P;
            S_MUL_P: state_d = S_MUL_I;
            S_MUL_I: state_d = S_MUL_D;
            S_MUL_D: state_d = S_OUT;
            S_OUT:   state_d = last_ch ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            duty_valid   <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_valid <= (state_q == S_OUT) && last_ch;
            if (state_q == S_IDLE && tick)      ch_q <= '0;
            else if (state_q == S_OUT && !last_ch) ch_q <= ch_q + CH_W'(1);
            if (tick && busy)       tick_overrun <= 1'b1;
            else if (clear_overrun) tick_overrun <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sp_r <= '0; st_r <= '0; kp_r <= '0; ki_r <= '0; kd_r <= '0;
            plim_r <= '0; ilim_r <= '0; db_r <= '0; mode_r <= '0;
            err_r <= '0; int_r <= '0; der_r <= '0;
            acc_q <= '0;
            duty  <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                integ_q[k] <= '0;
                eprev_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    sp_r   <= setpoint[base +: DATA_W];
                    st_r   <= state[base +: DATA_W];
                    kp_r   <= Kp[base +: DATA_W];
                    ki_r   <= Ki[base +: DATA_W];
                    kd_r   <= Kd[base +: DATA_W];
                    plim_r <= PWMLimit[base +: DATA_W];
                    ilim_r <= IntegralLimit[base +: DATA_W];
                    db_r   <= deadband[base +: DATA_W];
                    mode_r <= control_mode[ch_q*8 +: 8];
                    acc_q  <= '0;
                end
                S_MUL_P: begin
                    acc_q <= acc_t'(prod);
                    err_r <= err_c;
                    int_r <= int_c;
                    der_r <= der_c;
                end
                S_MUL_I: acc_q <= acc_q + acc_t'(prod);
                // PI mode still spends this cycle so timing is mode-independent.
                S_MUL_D: if (mode_r != MODE_PI) acc_q <= acc_q + acc_t'(prod);
                S_OUT: begin
                    if (mode_r == MODE_PID || mode_r == MODE_PI) begin
                        duty[base +: DATA_W] <= pid_duty;
                        integ_q[ch_q]        <= int_r;
                        eprev_q[ch_q]        <= err_r;
                    end else if (mode_r == MODE_DIRECT) begin
                        duty[base +: DATA_W] <= direct_duty;
                    end else begin
                        // MODE_DISABLED and all reserved encodings.
                        duty[base +: DATA_W] <= '0;
                        integ_q[ch_q]        <= '0;
                        eprev_q[ch_q]        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_motor_pid.sv
// Scoreboard bench for multi_motor_pid: each control tick pushes the four
// hand-computed duties into a queue; a monitor pops and compares on duty_valid.
// PERIOD is 22 cycles (5*4+1 = 21 < 22).
module tb_multi_motor_pid;
    localparam int NCH = 4;
    localparam int DW  = 24;

    logic CLK = 1'b0;
    logic reset;
    logic [NCH*DW-1:0] setpoint, state, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband;
    logic [NCH*8-1:0]  control_mode;
    logic [NCH*DW-1:0] duty;
    logic duty_valid, busy, tick_overrun, clear_overrun;

    always #5 CLK = ~CLK;

    multi_motor_pid #(
        .NUM_CHANNELS (NCH),
        .DATA_W       (DW),
        .CLOCK_FREQ   (22),
        .CONTROL_FREQ (1),
        .ERR_SHIFT    (10)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .setpoint      (setpoint),
        .state         (state),
        .Kp            (Kp),
        .Ki            (Ki),
        .Kd            (Kd),
        .PWMLimit      (PWMLimit),
        .IntegralLimit (IntegralLimit),
        .deadband      (deadband),
        .control_mode  (control_mode),
        .duty          (duty),
        .duty_valid    (duty_valid),
        .busy          (busy),
        .tick_overrun  (tick_overrun),
        .clear_overrun (clear_overrun)
    );

    typedef logic [NCH*DW-1:0] exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   prev0  = 0;
    int   sp[NCH], st[NCH], kp[NCH], ki[NCH], kd[NCH], pl[NCH], il[NCH], db[NCH], md[NCH];

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    function automatic int duty_of(input int k);
        return int'($signed(duty[k*DW +: DW]));
    endfunction

    task automatic cfg(input int k, input int a_sp, input int a_st, input int a_kp, input int a_ki,
                       input int a_kd, input int a_pl, input int a_il, input int a_db, input int a_md);
        sp[k] = a_sp; st[k] = a_st; kp[k] = a_kp; ki[k] = a_ki; kd[k] = a_kd;
        pl[k] = a_pl; il[k] = a_il; db[k] = a_db; md[k] = a_md;
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            setpoint[k*DW +: DW]      = sp[k][DW-1:0];
            state[k*DW +: DW]         = st[k][DW-1:0];
            Kp[k*DW +: DW]            = kp[k][DW-1:0];
            Ki[k*DW +: DW]            = ki[k][DW-1:0];
            Kd[k*DW +: DW]            = kd[k][DW-1:0];
            PWMLimit[k*DW +: DW]      = pl[k][DW-1:0];
            IntegralLimit[k*DW +: DW] = il[k][DW-1:0];
            deadband[k*DW +: DW]      = db[k][DW-1:0];
            control_mode[k*8 +: 8]    = md[k][7:0];
        end
    endtask

    task automatic push_exp(input int e0, input int e1, input int e2, input int e3);
        exp_t e;
        e[0*DW +: DW] = e0[DW-1:0];
        e[1*DW +: DW] = e1[DW-1:0];
        e[2*DW +: DW] = e2[DW-1:0];
        e[3*DW +: DW] = e3[DW-1:0];
        exp_q.push_back(e);
    endtask

    // Waits for busy (cycle T+1), then follows the run to duty_valid.
    // duty0 must still be old in cycle T+5 and new in cycle T+6.
    task automatic run_tick(input string nm, input bit ovr, input int old0, input int new0);
        int n;
        n = 0;
        while (!busy && n < 60) begin @(negedge CLK); n++; end
        check({nm, "_start"}, int'(busy), 1);
        if (!busy) return;
        n = 0;
        while (!duty_valid && n < 40) begin
            @(negedge CLK);
            n++;
            if (n == 3 && ovr) begin
                force dut.tick = 1'b1;   // extra tick while busy, together with a clear
                clear_overrun = 1'b1;
            end
            if (n == 4) begin
                if (ovr) begin
                    release dut.tick;
                    clear_overrun = 1'b0;
                    check({nm, "_overrun_set_wins"}, int'(tick_overrun), 1);
                end
                check({nm, "_duty0_hold_T5"}, duty_of(0), old0);
            end
            if (n == 5) check({nm, "_duty0_upd_T6"}, duty_of(0), new0);
        end
        check({nm, "_valid_latency"}, n, 20);
        check({nm, "_busy_drop"}, int'(busy), 0);
    endtask

    task automatic step(input string nm, input int e0, input int e1, input int e2, input int e3,
                        input bit ovr);
        drive();
        push_exp(e0, e1, e2, e3);
        run_tick(nm, ovr, prev0, e0);
        prev0 = e0;
    endtask

    // Monitor: compares every presented result against the scoreboard.
    initial begin
        exp_t e;
        int   vnum;
        vnum = 0;
        forever begin
            @(negedge CLK);
            if (duty_valid) begin
                vnum++;
                if (exp_q.size() == 0) begin
                    check($sformatf("valid%0d_unexpected", vnum), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < NCH; k++)
                        check($sformatf("valid%0d_duty%0d", vnum, k), duty_of(k),
                              int'($signed(e[k*DW +: DW])));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        clear_overrun = 1'b0;
        for (int k = 0; k < NCH; k++) cfg(k, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        drive();
        repeat (3) @(negedge CLK);
        check("rst_duty_zero", int'(duty == '0), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_duty_valid", int'(duty_valid), 0);
        check("rst_overrun", int'(tick_overrun), 0);

        // ch0 step, ch1 direct clamp, ch2 deadband edge (40), ch3 just outside (41)
        cfg(0, 10240, 0, 2, 0, 0, 1000, 0, 0, 0);
        cfg(1, -5000, 0, 0, 0, 0, 3000, 0, 0, 3);
        cfg(2, 40960, 0, 1, 0, 0, 1000, 0, 40, 0);
        cfg(3, 41984, 0, 1, 0, 0, 1000, 0, 40, 0);
        drive();
        reset = 1'b0;
        step("t1_step", 20, -3000, 0, 41, 1'b0);

        // Integral windup, limit 25, err 10 per tick
        cfg(0, 10240, 0, 0, 1, 0, 1000, 25, 0, 0);
        step("t2_int", 10, -3000, 0, 41, 1'b0);
        step("t3_int", 20, -3000, 0, 41, 1'b0);
        step("t4_int", 25, -3000, 0, 41, 1'b0);
        step("t5_int", 25, -3000, 0, 41, 1'b0);
        md[0] = 2;
        step("t6_disabled", 0, -3000, 0, 41, 1'b0);
        md[0] = 0;
        step("t7_restart", 10, -3000, 0, 41, 1'b0);

        // Derivative: err 0 then 100 with Kd=100000 -> acc 1e7 > 2^23, clamps to 1000
        cfg(0, 0, 0, 0, 0, 0, 1000, 25, 0, 0);
        step("t8_err0", 0, -3000, 0, 41, 1'b0);
        cfg(0, 102400, 0, 0, 0, 100000, 1000, 25, 0, 0);
        step("t9_deriv_sat", 1000, -3000, 0, 41, 1'b0);
        cfg(0, 0, 0, 0, 0, 0, 1000, 25, 0, 0);
        step("t10_err0", 0, -3000, 0, 41, 1'b0);
        cfg(0, 102400, 0, 1, 0, 100000, 1000, 25, 0, 1);
        step("t11_pi_skip_d", 100, -3000, 0, 41, 1'b0);

        // Negative limits act as 0; reserved mode acts as disabled
        cfg(1, -5000, 0, 0, 0, 0, -1, 0, 0, 3);
        cfg(2, 40960, 0, 1, 0, 0, 1000, 0, 39, 7);
        cfg(3, 41984, 0, 1, 0, 0, -5, 0, 40, 0);
        step("t12_neg_limits", 100, 0, 0, 0, 1'b0);

        // Negative errors: integral 25-10=15, deadband on |acc|
        cfg(0, 0, 10240, 1, 0, 0, 1000, 25, 0, 0);
        cfg(1, 5000, 0, 0, 0, 0, 3000, 0, 0, 3);
        cfg(2, 0, 40960, 1, 0, 0, 1000, 0, 40, 0);
        cfg(3, 0, 41984, 1, 0, 0, 1000, 0, 40, 0);
        step("t13_negative", -10, 3000, 0, -41, 1'b0);

        // Overrun: extra tick mid-run is dropped, run completes normally (15+10 -> 25)
        cfg(0, 10240, 0, 0, 1, 0, 1000, 25, 0, 0);
        step("t14_overrun", 25, 3000, 0, -41, 1'b1);
        check("overrun_sticky", int'(tick_overrun), 1);
        clear_overrun = 1'b1;
        @(negedge CLK);
        clear_overrun = 1'b0;
        check("overrun_cleared", int'(tick_overrun), 0);

        // Mid-sequence reset at T+7, after ch0 was written at T+5
        n = 0;
        while (!busy && n < 60) begin @(negedge CLK); n++; end
        check("rst_tick_start", int'(busy), 1);
        repeat (6) @(negedge CLK);
        check("pre_rst_duty0", duty_of(0), 25);
        reset = 1'b1;
        #1;
        check("mid_rst_duty_zero", int'(duty == '0), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_duty_valid", int'(duty_valid), 0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        prev0 = 0;

        // Integral must restart from 0 after reset
        step("t16_after_reset", 10, 3000, 0, -41, 1'b0);
        check("overrun_after_reset", int'(tick_overrun), 0);

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
